// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flags-byte layout and interface state encoding for the UART ALU
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_OVF   = 1;
    localparam int FLG_CARRY = 2;

    localparam logic [2:0] ST_A        = 3'd0;
    localparam logic [2:0] ST_B        = 3'd1;
    localparam logic [2:0] ST_OP       = 3'd2;
    localparam logic [2:0] ST_CALC     = 3'd3;
    localparam logic [2:0] ST_TX_RES   = 3'd4;
    localparam logic [2:0] ST_WAIT_RES = 3'd5;
    localparam logic [2:0] ST_TX_FLG   = 3'd6;
    localparam logic [2:0] ST_WAIT_FLG = 3'd7;

    typedef enum logic [2:0] {
        S_A        = ST_A,
        S_B        = ST_B,
        S_OP       = ST_OP,
        S_CALC     = ST_CALC,
        S_TX_RES   = ST_TX_RES,
        S_WAIT_RES = ST_WAIT_RES,
        S_TX_FLG   = ST_TX_FLG,
        S_WAIT_FLG = ST_WAIT_FLG
    } state_t;

endpackage

// File: rtl/alu_uart_intf.sv
// rtl/alu_uart_intf.sv - sequences A/B/OP bytes from uart_rx into the alu and returns result and flags bytes via uart_tx
module alu_uart_intf
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic [NB_OP-1:0]   o_operacion,
    input  logic [NB_DATA-1:0] i_resultado,
    input  logic               i_zero,
    input  logic               i_overflow,
    input  logic               i_carry,
    output logic               o_busy
);

    if (NB_DATA != 8) begin : g_cfg_err
        $error("alu_uart_intf: NB_DATA must be 8");
    end

    state_t             state;
    state_t             state_next;
    logic [NB_DATA-1:0] dato_a;
    logic [NB_DATA-1:0] dato_b;
    logic [NB_OP-1:0]   operacion;
    logic [NB_DATA-1:0] tx_data;
    logic [NB_DATA-1:0] flg_reg;
    logic [NB_DATA-1:0] flags_byte;
    logic               tx_start;
    logic               busy;

    always_comb begin
        flags_byte            = '0;
        flags_byte[FLG_ZERO]  = i_zero;
        flags_byte[FLG_OVF]   = i_overflow;
        flags_byte[FLG_CARRY] = i_carry;
    end

    // tx_data doubles as the result holding register: it is loaded in S_CALC and
    // only switches to the flags byte once uart_tx acknowledges the result byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_A;
            dato_a    <= '0;
            dato_b    <= '0;
            operacion <= '0;
            tx_data   <= '0;
            flg_reg   <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_A:        if (i_rx_done) dato_a <= i_rx_data;
                S_B:        if (i_rx_done) dato_b <= i_rx_data;
                S_OP:       if (i_rx_done) operacion <= i_rx_data[NB_OP-1:0];
                S_CALC: begin
                    tx_data <= i_resultado;
                    flg_reg <= flags_byte;
                end
                S_WAIT_RES: if (i_tx_done) tx_data <= flg_reg;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        busy       = 1'b1;
        case (state)
            S_A: begin
                busy = 1'b0;
                if (i_rx_done) state_next = S_B;
            end
            S_B: begin
                busy = 1'b0;
                if (i_rx_done) state_next = S_OP;
            end
            S_OP: begin
                busy = 1'b0;
                if (i_rx_done) state_next = S_CALC;
            end
            S_CALC:     state_next = S_TX_RES;
            S_TX_RES: begin
                tx_start   = 1'b1;
                state_next = S_WAIT_RES;
            end
            S_WAIT_RES: if (i_tx_done) state_next = S_TX_FLG;
            S_TX_FLG: begin
                tx_start   = 1'b1;
                state_next = S_WAIT_FLG;
            end
            S_WAIT_FLG: if (i_tx_done) state_next = S_A;
            default:    state_next = S_A;
        endcase
    end

    assign o_tx_start  = tx_start;
    assign o_tx_data   = tx_data;
    assign o_datoA     = dato_a;
    assign o_datoB     = dato_b;
    assign o_operacion = operacion;
    assign o_busy      = busy;

endmodule

// File: doc/alu_uart_intf.md
Name: alu_uart_intf

Overview:
- Serial-side counterpart of the switch/button ALU front-end: operands and opcode arrive as bytes from the UART receiver instead of switches/BTN.
- Results leave as bytes to the UART transmitter instead of LEDs.
- Sits between uart_rx, alu and uart_tx in the UART-ALU top.
- Sequences A → B → OP reception, presents the registered operands to the combinational alu, then transmits a result byte followed by a flags byte.

Parameters:
- NB_DATA, 8, UART byte width and ALU operand width. Must equal 8; any other value is a configuration error.
- NB_OP, 6, opcode width driven to alu.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- i_rx_data  in  NB_DATA  byte from uart_rx, valid while i_rx_done=1
- i_rx_done  in  1  one-cycle pulse, new byte available
- i_tx_done  in  1  one-cycle pulse, uart_tx finished the current byte
- o_tx_start  out  1  one-cycle pulse, launch transmission of o_tx_data
- o_tx_data  out  NB_DATA  byte to uart_tx; held stable from o_tx_start until the matching i_tx_done
- o_datoA  out  NB_DATA  registered operand A to alu
- o_datoB  out  NB_DATA  registered operand B to alu
- o_operacion  out  NB_OP  registered opcode to alu (rx byte bits [5:0])
- i_resultado  in  NB_DATA  alu result
- i_zero, i_overflow, i_carry  in  1 each  alu flags
- o_busy  out  1  high while a result/flags transmission is pending

Behaviour:
- States: S_A, S_B, S_OP, S_CALC, S_TX_RES, S_WAIT_RES, S_TX_FLG, S_WAIT_FLG.
- Reset: state S_A; o_datoA, o_datoB, o_operacion, o_tx_data = 0; o_tx_start = 0; o_busy = 0. Reset mid-transfer abandons the transfer; any later i_tx_done is ignored.
- S_A: on i_rx_done, o_datoA <= i_rx_data, go to S_B.
- S_B: on i_rx_done, o_datoB <= i_rx_data, go to S_OP.
- S_OP: on i_rx_done, o_operacion <= i_rx_data[5:0], go to S_CALC. Bits [7:6] are discarded. Invalid opcodes are passed through; the alu defines their result.
- S_CALC (exactly 1 cycle):
  - capture i_resultado into the result holding register;
  - capture {5'b0, i_carry, i_overflow, i_zero} into the flags holding register;
  - go to S_TX_RES.
- S_TX_RES (1 cycle): o_tx_start=1, o_tx_data=result; go to S_WAIT_RES.
- S_WAIT_RES: wait for i_tx_done, then go to S_TX_FLG.
- S_TX_FLG (1 cycle): o_tx_start=1, o_tx_data=flags; go to S_WAIT_FLG.
- S_WAIT_FLG: on i_tx_done, go to S_A. Operands and opcode keep their values until overwritten.
- Latency: opcode i_rx_done at cycle t → o_operacion valid at t+1 (S_CALC) → o_tx_start high at t+2 carrying the result.
- o_busy = 1 in S_CALC through S_WAIT_FLG, else 0.
- i_rx_done while o_busy=1: byte dropped; no register changes and no queueing.
- i_tx_done outside S_WAIT_RES/S_WAIT_FLG: ignored.
- i_rx_done and i_tx_done in the same cycle: each is evaluated only against the current state. The other is ignored unless it applies in the next state (it will not, since both are pulses).
- No timeout. A missing i_tx_done stalls the block until reset.

Decomposition:
- Shared package alu_pkg: opcode constants (ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRL 6'b000010, SRA 6'b000011), flags-byte bit positions (ZERO=0, OVF=1, CARRY=2), and state encoding localparams.
- No sub-module. The alu is instantiated beside this block at top level, not inside it.

Test Plan:
1. After reset, rx 0x05, 0x03, 0x20 (ADD) → o_datoA=0x05, o_datoB=0x03, o_operacion=6'b100000. tx bytes are 0x08 then 0x00. o_tx_start rises 2 cycles after the opcode i_rx_done.
2. rx 0x80, 0x80, 0x20 → tx 0x00 then 0x07 (carry, overflow, zero all set).
3. rx 0xF0, 0x0F, 0x24 (AND) → tx 0x00 then 0x01. o_busy high from S_CALC until the second i_tx_done.
4. Inject rx byte 0x55 while waiting in S_WAIT_RES → byte dropped; o_datoA unchanged; after the flags tx, the next A load accepts a fresh byte.
5. Assert reset in S_WAIT_FLG, then pulse i_tx_done → all outputs 0, state S_A, no o_tx_start. Stray i_tx_done in S_A changes nothing.
6. rx opcode byte 0xE6 → o_operacion=6'b100110 (XOR); upper bits ignored.
